// File: rtl/uart_cmd_responder_pkg.sv
// Shared definitions for the UART command responder.
//   state_e      FSM state encoding
//   *_DEF        default opcodes and read-timeout length
//   ERR_BYTE     response byte returned on unknown opcode / read timeout
//                (only when UART_CMD_ERR_RESP_EN is defined)
package uart_cmd_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_SEND = 3'd5
  } state_e;

  localparam logic [7:0]  WR_CMD_DEF = 8'hAA;
  localparam logic [7:0]  RD_CMD_DEF = 8'hBB;
  localparam logic [7:0]  ERR_BYTE   = 8'hEE;
  localparam int unsigned RD_TMO_DEF = 15;

endpackage

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Far-end command decoder of the UART link. Bytes from the UART receiver
//   are parsed as write (WR_CMD, addr, data) or read (RD_CMD, addr)
//   commands. Writes strobe the register file; reads strobe it, wait for
//   the read data and hand it to the UART transmitter.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   RX_P_DATA/VLD   received byte + 1-cycle valid pulse
//   RF_WrEn/RdEn    1-cycle register-file strobes
//   RF_Address      register address (low ADDR_W bits of address byte)
//   RF_WrData       register write data
//   RF_RdData/VLD   register read data + valid
//   TX_P_DATA/VLD   byte to transmit + request (held until TX_BUSY seen)
//   TX_BUSY         transmitter busy, already in the CLK domain
//   CMD_DROP        1-cycle pulse when a received byte is discarded
//
// Build option
//   UART_CMD_ERR_RESP_EN  when defined, an unknown opcode in IDLE or a read
//                         timeout sends ERR_BYTE (8'hEE) back instead of
//                         being silently ignored.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for an opcode byte
// ST_WR_ADDR | write opcode seen, next byte is the address
// ST_WR_DATA | address latched, next byte is write data -> RF_WrEn
// ST_RD_ADDR | read opcode seen, next byte is the address -> RF_RdEn
// ST_RD_WAIT | waiting for RF_RdData_VLD, bounded by RD_TMO cycles
// ST_TX_SEND | handing TX_P_DATA to the transmitter
module uart_cmd_responder
  import uart_cmd_responder_pkg::*;
#(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       ADDR_W = 4,
  parameter logic [DATA_W-1:0] WR_CMD = DATA_W'(WR_CMD_DEF),
  parameter logic [DATA_W-1:0] RD_CMD = DATA_W'(RD_CMD_DEF),
  parameter int unsigned       RD_TMO = RD_TMO_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  output logic              RF_WrEn,
  output logic              RF_RdEn,
  output logic [ADDR_W-1:0] RF_Address,
  output logic [DATA_W-1:0] RF_WrData,
  input  logic [DATA_W-1:0] RF_RdData,
  input  logic              RF_RdData_VLD,
  output logic [DATA_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD,
  input  logic              TX_BUSY,
  output logic              CMD_DROP
);

  // Down-counter loaded with RD_TMO-1 as RF_RdEn goes out; terminal count 0
  // is the last RD_WAIT cycle in which read data is still accepted, so the
  // FSM spends exactly RD_TMO cycles in RD_WAIT.
  localparam int unsigned     TMO_W    = (RD_TMO > 2) ? $clog2(RD_TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(RD_TMO - 1);

`ifdef UART_CMD_ERR_RESP_EN
  localparam logic [DATA_W-1:0] ERR_RESP = DATA_W'(ERR_BYTE);
`endif

  state_e              state_q,      state_d;
  logic [TMO_W-1:0]    tmo_cnt_q,    tmo_cnt_d;
  logic                rf_wr_en_q,   rf_wr_en_d;
  logic                rf_rd_en_q,   rf_rd_en_d;
  logic [ADDR_W-1:0]   rf_address_q, rf_address_d;
  logic [DATA_W-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic [DATA_W-1:0]   tx_p_data_q,  tx_p_data_d;
  logic                tx_d_vld_q,   tx_d_vld_d;
  logic                cmd_drop_q,   cmd_drop_d;

  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_address_d = rf_address_q;
    rf_wr_data_d = rf_wr_data_q;
    tx_p_data_d  = tx_p_data_q;
    tx_d_vld_d   = tx_d_vld_q;
    cmd_drop_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            state_d = ST_WR_ADDR;
          end else if (RX_P_DATA == RD_CMD) begin
            state_d = ST_RD_ADDR;
          end else begin
`ifdef UART_CMD_ERR_RESP_EN
            tx_p_data_d = ERR_RESP;
            state_d     = ST_TX_SEND;
`else
            state_d     = ST_IDLE;
`endif
          end
        end
      end

      // Address and data slots take any byte literally, opcodes included.
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          rf_address_d = RX_P_DATA[ADDR_W-1:0];
          state_d      = ST_WR_DATA;
        end
      end

      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          rf_wr_data_d = RX_P_DATA;
          rf_wr_en_d   = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          rf_address_d = RX_P_DATA[ADDR_W-1:0];
          rf_rd_en_d   = 1'b1;
          tmo_cnt_d    = TMO_LOAD;
          state_d      = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        cmd_drop_d = RX_D_VLD;
        if (RF_RdData_VLD) begin
          tx_p_data_d = RF_RdData;
          tmo_cnt_d   = '0;
          state_d     = ST_TX_SEND;
        end else if (tmo_cnt_q == '0) begin
`ifdef UART_CMD_ERR_RESP_EN
          tx_p_data_d = ERR_RESP;
          state_d     = ST_TX_SEND;
`else
          state_d     = ST_IDLE;
`endif
        end else begin
          tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
        end
      end

      // Raise the request only while the transmitter is idle, then hold it
      // (data frozen) until the transmitter reports busy, i.e. has taken it.
      ST_TX_SEND: begin
        cmd_drop_d = RX_D_VLD;
        if (!tx_d_vld_q) begin
          if (!TX_BUSY) begin
            tx_d_vld_d = 1'b1;
          end
        end else if (TX_BUSY) begin
          tx_d_vld_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        tx_d_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      tmo_cnt_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_address_q <= '0;
      rf_wr_data_q <= '0;
      tx_p_data_q  <= '0;
      tx_d_vld_q   <= 1'b0;
      cmd_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_address_q <= rf_address_d;
      rf_wr_data_q <= rf_wr_data_d;
      tx_p_data_q  <= tx_p_data_d;
      tx_d_vld_q   <= tx_d_vld_d;
      cmd_drop_q   <= cmd_drop_d;
    end
  end

  assign RF_WrEn    = rf_wr_en_q;
  assign RF_RdEn    = rf_rd_en_q;
  assign RF_Address = rf_address_q;
  assign RF_WrData  = rf_wr_data_q;
  assign TX_P_DATA  = tx_p_data_q;
  assign TX_D_VLD   = tx_d_vld_q;
  assign CMD_DROP   = cmd_drop_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic       RF_WrEn, RF_RdEn;
  logic [3:0] RF_Address;
  logic [7:0] RF_WrData;
  logic [7:0] RF_RdData = 8'h00;
  logic       RF_RdData_VLD = 1'b0;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       TX_BUSY = 1'b0;
  logic       CMD_DROP;

  uart_cmd_responder dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .CMD_DROP(CMD_DROP)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference register contents, updated from the commands the bench issues.
  logic [7:0] ref_mem [16];
  // Register file as the DUT sees it, updated only by DUT write strobes.
  logic [7:0] rf_mem [16];
  logic       load_req = 1'b0;

  // Bus monitor: counts strobes, logs each new transmit request.
  int         wr_cnt = 0, rd_cnt = 0, both_cnt = 0, instab_cnt = 0;
  logic       prev_vld = 1'b0;
  logic [7:0] prev_tx = 8'h00;
  logic [7:0] tx_q [$];

  always @(posedge CLK) begin
    if (load_req) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= ref_mem[i];
    end else if (RF_WrEn) begin
      rf_mem[RF_Address] <= RF_WrData;
    end
    if (RF_WrEn) wr_cnt <= wr_cnt + 1;
    if (RF_RdEn) rd_cnt <= rd_cnt + 1;
    if (RF_WrEn && RF_RdEn) both_cnt <= both_cnt + 1;
    if (TX_D_VLD && !prev_vld) tx_q.push_back(TX_P_DATA);
    if (TX_D_VLD && prev_vld && TX_P_DATA !== prev_tx) instab_cnt <= instab_cnt + 1;
    prev_vld <= TX_D_VLD;
    prev_tx  <= TX_P_DATA;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
  endtask

  // Waits for a transmit request, checks its byte, keeps TX_BUSY low for
  // 'hold' extra cycles (request must persist), then accepts it.
  task automatic complete_tx(input logic [7:0] exp, input int hold);
    int i;
    bool_wait: for (i = 0; i < 40; i++) begin
      if (TX_D_VLD === 1'b1) break;
      tick(1);
    end
    checks++;
    if (TX_D_VLD !== 1'b1) begin
      errors++;
      $display("FAIL tx_req_timeout: TX_D_VLD=%b after 40 cycles, required 1", TX_D_VLD);
      return;
    end
    checks++;
    if (TX_P_DATA !== exp) begin
      errors++;
      $display("FAIL tx_data: got %02h, required %02h", TX_P_DATA, exp);
    end
    for (int h = 0; h < hold; h++) begin
      tick(1);
      checks++;
      if (TX_D_VLD !== 1'b1 || TX_P_DATA !== exp) begin
        errors++;
        $display("FAIL tx_hold: vld=%b data=%02h, required vld=1 data=%02h", TX_D_VLD, TX_P_DATA, exp);
      end
    end
    TX_BUSY = 1'b1;
    tick(1);
    checks++;
    if (TX_D_VLD !== 1'b0) begin
      errors++;
      $display("FAIL tx_release: TX_D_VLD=%b one cycle after TX_BUSY, required 0", TX_D_VLD);
    end
    tick($urandom_range(1, 3));
    TX_BUSY = 1'b0;
    tick(2);
    checks++;
    if (TX_D_VLD !== 1'b0) begin
      errors++;
      $display("FAIL tx_resend: TX_D_VLD=%b after transfer done, required 0", TX_D_VLD);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
    checks++;
    if (RF_WrEn !== 1'b1 || RF_RdEn !== 1'b0 || RF_Address !== a[3:0] || RF_WrData !== d) begin
      errors++;
      $display("FAIL write_strobe: wr=%b rd=%b addr=%h data=%02h, required wr=1 rd=0 addr=%h data=%02h",
               RF_WrEn, RF_RdEn, RF_Address, RF_WrData, a[3:0], d);
    end
    ref_mem[a[3:0]] = d;
    tick(1);
    checks++;
    if (RF_WrEn !== 1'b0) begin
      errors++;
      $display("FAIL write_pulse: RF_WrEn=%b second cycle, required 0", RF_WrEn);
    end
  endtask

  // Issues a read and answers it from rf_mem after 'dly' cycles (1 = in the
  // cycle RF_RdEn is visible). Does not complete the transmit handshake.
  task automatic start_read(input logic [7:0] a, input int dly);
    logic [3:0] seen;
    send_byte(8'hBB);
    send_byte(a);
    checks++;
    if (RF_RdEn !== 1'b1 || RF_WrEn !== 1'b0 || RF_Address !== a[3:0]) begin
      errors++;
      $display("FAIL read_strobe: rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=%h",
               RF_RdEn, RF_WrEn, RF_Address, a[3:0]);
    end
    seen = RF_Address;
    if (dly >= 2) begin
      tick(1);
      checks++;
      if (RF_RdEn !== 1'b0) begin
        errors++;
        $display("FAIL read_pulse: RF_RdEn=%b second cycle, required 0", RF_RdEn);
      end
      tick(dly - 2);
    end
    RF_RdData     = rf_mem[seen];
    RF_RdData_VLD = 1'b1;
    tick(1);
    RF_RdData_VLD = 1'b0;
    RF_RdData     = 8'($urandom);
  endtask

  task automatic do_read(input logic [7:0] a, input int dly, input int hold);
    logic [7:0] exp;
    exp = ref_mem[a[3:0]];
    start_read(a, dly);
    complete_tx(exp, hold);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    RX_D_VLD = 1'b1;
    RX_P_DATA = 8'hAA;
    tick(3);
    checks++;
    if ({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD, CMD_DROP} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: wr=%b rd=%b addr=%h wd=%02h tx=%02h vld=%b drop=%b, required all 0",
               RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD, CMD_DROP);
    end
    RX_D_VLD = 1'b0;
    RST = 1'b0;
    tick(1);
  endtask

  task automatic test_write();
    int tx0, rd0;
    tx0 = tx_q.size();
    rd0 = rd_cnt;
    do_write(8'h05, 8'h3C);
    do_write(8'hF9, 8'hBB);   // high address bits ignored, opcode value as data
    tick(3);
    checks++;
    if (tx_q.size() != tx0 || rd_cnt != rd0) begin
      errors++;
      $display("FAIL write_side_effects: tx=%0d rd=%0d, required tx=%0d rd=%0d",
               tx_q.size(), rd_cnt, tx0, rd0);
    end
  endtask

  task automatic test_read();
    do_write(8'h07, 8'h5A);
    do_read(8'h07, 3, 2);
    do_read(8'hA9, 1, 0);     // address byte with opcode-like upper bits
  endtask

  task automatic test_timeout();
    int tx0, wr0;
    tx0 = tx_q.size();
    wr0 = wr_cnt;
    start_read(8'h02, 1000);  // never answered within the window
    tick(28);
    RF_RdData = 8'h99;
    RF_RdData_VLD = 1'b1;     // late answer, must be ignored
    tick(1);
    RF_RdData_VLD = 1'b0;
`ifdef UART_CMD_ERR_RESP_EN
    complete_tx(8'hEE, 0);
    checks++;
    if (tx_q.size() != tx0 + 1) begin
      errors++;
      $display("FAIL timeout_err_resp: tx count %0d, required %0d", tx_q.size(), tx0 + 1);
    end
`else
    tick(3);
    checks++;
    if (tx_q.size() != tx0 || TX_D_VLD !== 1'b0 || wr_cnt != wr0) begin
      errors++;
      $display("FAIL timeout_no_resp: tx count %0d vld=%b wr=%0d, required %0d 0 %0d",
               tx_q.size(), TX_D_VLD, wr_cnt, tx0, wr0);
    end
`endif
    do_read(8'h07, 4, 1);
  endtask

  task automatic test_unknown();
    int tx0, wr0, rd0;
    tx0 = tx_q.size();
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    send_byte(8'h11);
`ifdef UART_CMD_ERR_RESP_EN
    complete_tx(8'hEE, 1);
`else
    tick(4);
`endif
    checks++;
    if (wr_cnt != wr0 || rd_cnt != rd0) begin
      errors++;
      $display("FAIL unknown_strobe: wr=%0d rd=%0d, required %0d %0d", wr_cnt, rd_cnt, wr0, rd0);
    end
`ifndef UART_CMD_ERR_RESP_EN
    checks++;
    if (tx_q.size() != tx0) begin
      errors++;
      $display("FAIL unknown_tx: tx count %0d, required %0d", tx_q.size(), tx0);
    end
`endif
  endtask

  task automatic test_drop();
    logic [7:0] exp;
    int wr0;
    exp = ref_mem[4];
    TX_BUSY = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h04);
    send_byte(8'h55);          // arrives in RD_WAIT
    checks++;
    if (CMD_DROP !== 1'b1) begin
      errors++;
      $display("FAIL drop_rd_wait: CMD_DROP=%b, required 1", CMD_DROP);
    end
    RF_RdData = rf_mem[4];
    RF_RdData_VLD = 1'b1;
    tick(1);
    RF_RdData_VLD = 1'b0;
    tick(2);
    checks++;
    if (TX_D_VLD !== 1'b0 || CMD_DROP !== 1'b0) begin
      errors++;
      $display("FAIL tx_wait_busy: vld=%b drop=%b while busy, required 0 0", TX_D_VLD, CMD_DROP);
    end
    wr0 = wr_cnt;
    send_byte(8'hAA);          // arrives in TX_SEND, must not start a write
    checks++;
    if (CMD_DROP !== 1'b1) begin
      errors++;
      $display("FAIL drop_tx_send: CMD_DROP=%b, required 1", CMD_DROP);
    end
    tick(1);
    checks++;
    if (CMD_DROP !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulse: CMD_DROP=%b second cycle, required 0", CMD_DROP);
    end
    TX_BUSY = 1'b0;
    complete_tx(exp, 1);
    do_write(8'h01, 8'hFF);
    checks++;
    if (wr_cnt != wr0 + 1) begin
      errors++;
      $display("FAIL drop_then_write: wr count %0d, required %0d", wr_cnt, wr0 + 1);
    end
    do_read(8'h01, 2, 0);
  endtask

  task automatic test_reset_mid();
    int wr0;
    logic [7:0] exp;
    wr0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h03);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    send_byte(8'h77);
`ifdef UART_CMD_ERR_RESP_EN
    complete_tx(8'hEE, 0);
`else
    tick(4);
`endif
    checks++;
    if (wr_cnt != wr0 || TX_D_VLD !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_cmd: wr=%0d vld=%b, required %0d 0", wr_cnt, TX_D_VLD, wr0);
    end
    // Reset while a transmit request is being held.
    exp = ref_mem[3];
    start_read(8'h03, 2);
    tick(2);
    RST = 1'b1;
    tick(1);
    checks++;
    if (TX_D_VLD !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx_drop: TX_D_VLD=%b in reset, required 0", TX_D_VLD);
    end
    RST = 1'b0;
    tick(3);
    checks++;
    if (TX_D_VLD !== 1'b0 || ref_mem[3] !== exp) begin
      errors++;
      $display("FAIL reset_tx_idle: TX_D_VLD=%b after reset, required 0", TX_D_VLD);
    end
    do_read(8'h03, 2, 0);
  endtask

  task automatic test_back_to_back();
    send_byte(8'hAA);
    send_byte(8'h0C);
    send_byte(8'hAA);
    checks++;
    if (RF_WrEn !== 1'b1 || RF_Address !== 4'hC || RF_WrData !== 8'hAA) begin
      errors++;
      $display("FAIL b2b_write: wr=%b addr=%h data=%02h, required 1 c aa", RF_WrEn, RF_Address, RF_WrData);
    end
    ref_mem[12] = 8'hAA;
    send_byte(8'hBB);
    send_byte(8'h0C);
    checks++;
    if (RF_RdEn !== 1'b1 || RF_WrEn !== 1'b0 || RF_Address !== 4'hC) begin
      errors++;
      $display("FAIL b2b_read: rd=%b wr=%b addr=%h, required 1 0 c", RF_RdEn, RF_WrEn, RF_Address);
    end
    RF_RdData = rf_mem[12];
    RF_RdData_VLD = 1'b1;
    tick(1);
    RF_RdData_VLD = 1'b0;
    complete_tx(8'hAA, 0);
  endtask

  task automatic test_random();
    logic [7:0] a, d;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) != 0) ? 8'hAA : 8'hBB;
      if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) != 0) ? 8'hAA : 8'hBB;
      if ($urandom_range(0, 1) != 0) do_write(a, d);
      else do_read(a, int'($urandom_range(1, 12)), int'($urandom_range(0, 3)));
      tick($urandom_range(0, 2));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'($urandom);
    load_req = 1'b1;
    tick(2);
    load_req = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_unknown();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    tick(2);
    checks++;
    if (both_cnt != 0 || instab_cnt != 0) begin
      errors++;
      $display("FAIL bus_rules: wr+rd together %0d times, tx data changed %0d times, required 0 0",
               both_cnt, instab_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
